// File: rtl/mmio_slot_arbiter.sv
// mmio_slot_arbiter: round-robin arbiter that shares one MMIO slot between
// NUM_REQ requesters. Each winner gets one complete slot transaction (bus
// drive, done wait, transaction_completed release), and a watchdog aborts
// transactions that the slot never completes.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   req/req_write               per-requester request and direction (1 = write)
//   req_addr/req_wdata          per-requester payload, 8 / 32 bits per lane
//   gnt                         one-hot grant, grant cycle through RELEASE
//   done                        one-hot single-cycle response pulse
//   resp_rdata/resp_*           captured response, valid while done is high
//   chip_select/read/write      slot controls, held stable during BUS
//   transaction_completed       slot release strobe (RELEASE cycle)
//   addr/wr_data                slot address and write data
//   rd_data/wr_done/rd_done     slot read data and completion pulses
//   slave_error/decode_error    slot status, only meaningful with a done pulse
module mmio_slot_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            resp_rdata,
  output logic                   resp_slave_err,
  output logic                   resp_decode_err,
  output logic                   resp_timeout,
  output logic                   chip_select,
  output logic                   read,
  output logic                   write,
  output logic                   transaction_completed,
  output logic [7:0]             addr,
  output logic [31:0]            wr_data,
  input  logic [31:0]            rd_data,
  input  logic                   wr_done,
  input  logic                   rd_done,
  input  logic                   slave_error,
  input  logic                   decode_error
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [IDX_W-1:0] last, last_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic [31:0]        resp_rdata_d, wr_data_d;
  logic [7:0]         addr_d;
  logic               resp_slave_err_d, resp_decode_err_d, resp_timeout_d;
  logic               chip_select_d, read_d, write_d, tc_d;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_write;
  logic [7:0]         arb_addr;
  logic [31:0]        arb_wdata;

  logic               slot_done;
  logic               timed_out;

  assign slot_done = wr_done | rd_done;
  assign timed_out = (cnt == CNT_LAST);

  // Round-robin search starting one past the previous winner.
  always_comb begin : arbiter
    int unsigned cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = last;
    arb_write = 1'b0;
    arb_addr  = '0;
    arb_wdata = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last) + i) % NUM_REQ;
      if (!arb_found && req[IDX_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
        arb_write = req_write[IDX_W'(cand)];
        arb_addr  = req_addr[8*cand +: 8];
        arb_wdata = req_wdata[32*cand +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a done pulse in the last watchdog cycle still counts as done.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:    if (arb_found) state_d = S_BUS;
      S_BUS:     if (slot_done || timed_out) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    gnt_d             = gnt;
    done_d            = '0;
    tc_d              = 1'b0;
    chip_select_d     = chip_select;
    read_d            = read;
    write_d           = write;
    addr_d            = addr;
    wr_data_d         = wr_data;
    resp_rdata_d      = resp_rdata;
    resp_slave_err_d  = resp_slave_err;
    resp_decode_err_d = resp_decode_err;
    resp_timeout_d    = resp_timeout;
    last_d            = last;
    cnt_d             = cnt;
    unique case (state)
      S_IDLE: begin
        if (arb_found) begin
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          last_d         = arb_idx;
          chip_select_d  = 1'b1;
          read_d         = ~arb_write;
          write_d        = arb_write;
          addr_d         = arb_addr;
          wr_data_d      = arb_wdata;
          cnt_d          = '0;
        end
      end
      S_BUS: begin
        if (!timed_out) cnt_d = cnt + CNT_W'(1);
        if (slot_done || timed_out) begin
          chip_select_d = 1'b0;
          read_d        = 1'b0;
          write_d       = 1'b0;
          tc_d          = 1'b1;
          done_d        = gnt;
          if (slot_done) begin
            resp_rdata_d      = write ? 32'h0 : rd_data;
            resp_slave_err_d  = slave_error;
            resp_decode_err_d = decode_error;
            resp_timeout_d    = 1'b0;
          end else begin
            resp_rdata_d      = 32'h0;
            resp_slave_err_d  = 1'b0;
            resp_decode_err_d = 1'b0;
            resp_timeout_d    = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        gnt_d = '0;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      gnt                   <= '0;
      done                  <= '0;
      transaction_completed <= 1'b0;
      chip_select           <= 1'b0;
      read                  <= 1'b0;
      write                 <= 1'b0;
      addr                  <= '0;
      wr_data               <= '0;
      resp_rdata            <= '0;
      resp_slave_err        <= 1'b0;
      resp_decode_err       <= 1'b0;
      resp_timeout          <= 1'b0;
      last                  <= LAST_RST;
      cnt                   <= '0;
    end else begin
      gnt                   <= gnt_d;
      done                  <= done_d;
      transaction_completed <= tc_d;
      chip_select           <= chip_select_d;
      read                  <= read_d;
      write                 <= write_d;
      addr                  <= addr_d;
      wr_data               <= wr_data_d;
      resp_rdata            <= resp_rdata_d;
      resp_slave_err        <= resp_slave_err_d;
      resp_decode_err       <= resp_decode_err_d;
      resp_timeout          <= resp_timeout_d;
      last                  <= last_d;
      cnt                   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mmio_slot_arbiter.sv
// Directed bench for mmio_slot_arbiter (NUM_REQ=2, TIMEOUT=8).
module tb_mmio_slot_arbiter;

  logic        clk;
  logic        arst_n;
  logic [1:0]  req, req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  gnt, done;
  logic [31:0] resp_rdata;
  logic        resp_slave_err, resp_decode_err, resp_timeout;
  logic        chip_select, read, write, transaction_completed;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        wr_done, rd_done, slave_error, decode_error;

  int checks = 0;
  int errors = 0;

  // Observations collected by do_txn.
  logic [1:0]  obs_gnt, obs_done, obs_gnt_rel;
  logic [7:0]  obs_addr;
  logic [31:0] obs_wdata, obs_rdata;
  logic        obs_read, obs_write, obs_stable, obs_tc, obs_cs_rel;
  logic        obs_serr, obs_derr, obs_to;
  int          obs_cs, obs_done_cyc;

  mmio_slot_arbiter #(.NUM_REQ(2), .TIMEOUT(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done),
    .resp_rdata(resp_rdata), .resp_slave_err(resp_slave_err),
    .resp_decode_err(resp_decode_err), .resp_timeout(resp_timeout),
    .chip_select(chip_select), .read(read), .write(write),
    .transaction_completed(transaction_completed),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .wr_done(wr_done), .rd_done(rd_done),
    .slave_error(slave_error), .decode_error(decode_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Idle slot: error flags sit at 1, which the arbiter must ignore.
  task automatic slot_idle();
    rd_done = 1'b0; wr_done = 1'b0;
    rd_data = 32'hBAD0_BAD0;
    slave_error = 1'b1; decode_error = 1'b0 | 1'b1;
  endtask

  // Issue one request from requester r; the slot answers in the done_at-th
  // cycle of chip_select (0 = never). Results go to the obs_* variables.
  task automatic do_txn(input int r, input logic w, input logic [7:0] a, input logic [31:0] wd,
                        input int done_at, input logic [31:0] rdv, input logic se, input logic de);
    int cyc;
    @(negedge clk);
    req = '0;
    req[r] = 1'b1;
    req_write[r] = w;
    req_addr[8*r +: 8] = a;
    req_wdata[32*r +: 32] = wd;
    obs_cs = 0; obs_done_cyc = -1; obs_stable = 1'b1; cyc = 0;
    obs_done = '0;
    for (int k = 0; k < 100 && obs_done_cyc < 0; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        obs_gnt = gnt; obs_addr = addr; obs_wdata = wr_data;
        obs_read = read; obs_write = write;
        req = '0;
        req_addr = ~req_addr; req_wdata = ~req_wdata; req_write = ~req_write;
      end else if (chip_select && (addr !== obs_addr || wr_data !== obs_wdata ||
                                   read !== obs_read || write !== obs_write)) begin
        obs_stable = 1'b0;
      end
      if (chip_select) obs_cs++;
      if (chip_select && obs_cs == done_at) begin
        rd_done = ~w; wr_done = w; rd_data = rdv; slave_error = se; decode_error = de;
      end else begin
        slot_idle();
      end
      if (done !== 2'b00) begin
        obs_done = done; obs_done_cyc = cyc; obs_tc = transaction_completed;
        obs_cs_rel = chip_select; obs_gnt_rel = gnt; obs_rdata = resp_rdata;
        obs_serr = resp_slave_err; obs_derr = resp_decode_err; obs_to = resp_timeout;
      end
    end
  endtask

  task automatic test_reset();
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    slot_idle();
    arst_n = 1'b1;
    #3 arst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, done, resp_rdata, resp_slave_err, resp_decode_err, resp_timeout, chip_select,
         read, write, transaction_completed, addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b cs=%b rdata=%h addr=%h wdata=%h, required all 0",
               gnt, done, chip_select, resp_rdata, addr, wr_data);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_txn(0, 1'b0, 8'h08, 32'h0, 3, 32'h0000_01A5, 1'b0, 1'b0);
    checks++;
    if (obs_gnt !== 2'b01 || obs_read !== 1'b1 || obs_write !== 1'b0 || obs_addr !== 8'h08) begin
      errors++;
      $display("FAIL read_bus: gnt=%b rd=%b wr=%b addr=%h, required 01 1 0 08",
               obs_gnt, obs_read, obs_write, obs_addr);
    end
    checks++;
    if (obs_stable !== 1'b1 || obs_cs !== 3) begin
      errors++;
      $display("FAIL read_hold: stable=%b cs_cycles=%0d, required 1 3", obs_stable, obs_cs);
    end
    checks++;
    if (obs_done_cyc !== 4 || obs_done !== 2'b01 || obs_tc !== 1'b1 || obs_cs_rel !== 1'b0 ||
        obs_gnt_rel !== 2'b01) begin
      errors++;
      $display("FAIL read_release: cyc=%0d done=%b tc=%b cs=%b gnt=%b, required 4 01 1 0 01",
               obs_done_cyc, obs_done, obs_tc, obs_cs_rel, obs_gnt_rel);
    end
    checks++;
    if (obs_rdata !== 32'h1A5 || obs_serr !== 1'b0 || obs_derr !== 1'b0 || obs_to !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: rdata=%h serr=%b derr=%b to=%b, required 000001a5 0 0 0",
               obs_rdata, obs_serr, obs_derr, obs_to);
    end
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || transaction_completed !== 1'b0 || gnt !== 2'b00 || resp_rdata !== 32'h1A5) begin
      errors++;
      $display("FAIL read_after: done=%b tc=%b gnt=%b rdata=%h, required 00 0 00 000001a5",
               done, transaction_completed, gnt, resp_rdata);
    end
  endtask

  task automatic test_write_error();
    do_txn(1, 1'b1, 8'h00, 32'h0000_00FF, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checks++;
    if (obs_gnt !== 2'b10 || obs_write !== 1'b1 || obs_read !== 1'b0 || obs_wdata !== 32'hFF ||
        obs_addr !== 8'h00) begin
      errors++;
      $display("FAIL write_bus: gnt=%b wr=%b rd=%b wdata=%h addr=%h, required 10 1 0 000000ff 00",
               obs_gnt, obs_write, obs_read, obs_wdata, obs_addr);
    end
    checks++;
    if (obs_done !== 2'b10 || obs_done_cyc !== 4 || obs_serr !== 1'b1 || obs_derr !== 1'b0 ||
        obs_rdata !== 32'h0 || obs_to !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: done=%b cyc=%0d serr=%b derr=%b rdata=%h to=%b, required 10 4 1 0 0 0",
               obs_done, obs_done_cyc, obs_serr, obs_derr, obs_rdata, obs_to);
    end
  endtask

  task automatic test_fairness();
    int cyc, ndone, prev, cs_cnt;
    logic onehot_ok, order_ok, gap_ok, data_ok, quiet_ok;
    logic [1:0] exp_done;
    @(negedge clk);
    req = 2'b11; req_write = 2'b00; req_addr = 16'h2010;
    cyc = 0; ndone = 0; prev = -1; cs_cnt = 0;
    onehot_ok = 1'b1; order_ok = 1'b1; gap_ok = 1'b1; data_ok = 1'b1;
    for (int k = 0; k < 60 && ndone < 6; k++) begin
      @(negedge clk);
      cyc++;
      if (gnt == 2'b11) onehot_ok = 1'b0;
      cs_cnt = chip_select ? cs_cnt + 1 : 0;
      if (cs_cnt == 3) begin
        rd_done = 1'b1; rd_data = 32'h100 + 32'(ndone); slave_error = 1'b0; decode_error = 1'b0;
      end else begin
        slot_idle();
      end
      if (done !== 2'b00) begin
        exp_done = (ndone % 2 == 0) ? 2'b01 : 2'b10;
        if (done !== exp_done) order_ok = 1'b0;
        if (resp_rdata !== 32'h100 + 32'(ndone)) data_ok = 1'b0;
        if (prev >= 0 && cyc - prev != 5) gap_ok = 1'b0;
        prev = cyc;
        ndone++;
        if (ndone == 6) req = 2'b00;
      end
    end
    checks++;
    if (ndone !== 6) begin
      errors++;
      $display("FAIL fair_count: done pulses=%0d, required 6", ndone);
    end
    checks++;
    if (order_ok !== 1'b1) begin
      errors++;
      $display("FAIL fair_order: order_ok=%b, required 1 (grants 0,1,0,1,0,1)", order_ok);
    end
    checks++;
    if (gap_ok !== 1'b1 || onehot_ok !== 1'b1) begin
      errors++;
      $display("FAIL fair_timing: gap_ok=%b onehot_ok=%b, required 1 1", gap_ok, onehot_ok);
    end
    checks++;
    if (data_ok !== 1'b1) begin
      errors++;
      $display("FAIL fair_data: data_ok=%b, required 1", data_ok);
    end
    quiet_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done !== 2'b00 || gnt !== 2'b00 || chip_select !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (quiet_ok !== 1'b1) begin
      errors++;
      $display("FAIL fair_quiet: quiet_ok=%b, required 1 after requests drop", quiet_ok);
    end
  endtask

  task automatic test_timeout();
    do_txn(0, 1'b0, 8'h33, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs_cs !== 8 || obs_done_cyc !== 9 || obs_done !== 2'b01) begin
      errors++;
      $display("FAIL timeout_timing: cs_cycles=%0d cyc=%0d done=%b, required 8 9 01",
               obs_cs, obs_done_cyc, obs_done);
    end
    checks++;
    if (obs_to !== 1'b1 || obs_serr !== 1'b0 || obs_derr !== 1'b0 || obs_rdata !== 32'h0 || obs_tc !== 1'b1) begin
      errors++;
      $display("FAIL timeout_resp: to=%b serr=%b derr=%b rdata=%h tc=%b, required 1 0 0 0 1",
               obs_to, obs_serr, obs_derr, obs_rdata, obs_tc);
    end
    do_txn(1, 1'b0, 8'h21, 32'h0, 3, 32'h0000_5A5A, 1'b0, 1'b0);
    checks++;
    if (obs_done !== 2'b10 || obs_done_cyc !== 4 || obs_to !== 1'b0 || obs_rdata !== 32'h5A5A) begin
      errors++;
      $display("FAIL timeout_recover: done=%b cyc=%0d to=%b rdata=%h, required 10 4 0 00005a5a",
               obs_done, obs_done_cyc, obs_to, obs_rdata);
    end
  endtask

  task automatic test_timeout_race();
    do_txn(0, 1'b0, 8'h40, 32'h0, 8, 32'h0000_0077, 1'b0, 1'b1);
    checks++;
    if (obs_done !== 2'b01 || obs_done_cyc !== 9 || obs_cs !== 8) begin
      errors++;
      $display("FAIL race_timing: done=%b cyc=%0d cs_cycles=%0d, required 01 9 8",
               obs_done, obs_done_cyc, obs_cs);
    end
    checks++;
    if (obs_to !== 1'b0 || obs_serr !== 1'b0 || obs_derr !== 1'b1 || obs_rdata !== 32'h77) begin
      errors++;
      $display("FAIL race_resp: to=%b serr=%b derr=%b rdata=%h, required 0 0 1 00000077",
               obs_to, obs_serr, obs_derr, obs_rdata);
    end
  endtask

  task automatic test_reset_mid_bus();
    logic quiet_ok;
    @(negedge clk);
    req = 2'b01; req_write = 2'b00; req_addr = 16'h0044;
    @(negedge clk);
    checks++;
    if (chip_select !== 1'b1 || gnt !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre: cs=%b gnt=%b, required 1 01", chip_select, gnt);
    end
    req = 2'b00;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, resp_rdata, resp_slave_err, resp_decode_err, resp_timeout, chip_select,
         read, write, transaction_completed, addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL rst_async: gnt=%b cs=%b rd=%b addr=%h, required all 0", gnt, chip_select, read, addr);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    quiet_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00 || chip_select !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (quiet_ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_quiet: quiet_ok=%b, required 1 (no done after reset)", quiet_ok);
    end
    do_txn(1, 1'b1, 8'h10, 32'h0000_CAFE, 3, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs_gnt !== 2'b10 || obs_done !== 2'b10 || obs_done_cyc !== 4 || obs_wdata !== 32'hCAFE ||
        obs_serr !== 1'b0 || obs_to !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: gnt=%b done=%b cyc=%0d wdata=%h serr=%b to=%b, required 10 10 4 0000cafe 0 0",
               obs_gnt, obs_done, obs_done_cyc, obs_wdata, obs_serr, obs_to);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_error();
    test_fairness();
    test_timeout();
    test_timeout_race();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
